// File: rtl/toy_mem_pkg.sv
// Shared types and constants for the toy unified instruction/data memory.
package toy_mem_pkg;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;

    localparam logic DRW_RD = 1'b0;
    localparam logic DRW_WR = 1'b1;

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    // True when any word-address bit above the array index is set.
    function automatic logic addr_oor(input logic [ADDR_W-1:0] addr, input int unsigned aw);
        return (addr >> aw) != '0;
    endfunction

endpackage

// File: rtl/toy_mem_array.sv
// Two-read/one-write word storage with registered read ports; the instruction
// port forwards same-edge write data (write-first).
module toy_mem_array
    import toy_mem_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ird_en_i,
    input  logic              ird_zero_i,
    input  logic [AW-1:0]     ird_idx_i,
    output logic [DATA_W-1:0] ird_data_o,
    input  logic              drd_en_i,
    input  logic              drd_zero_i,
    input  logic [AW-1:0]     drd_idx_i,
    output logic [DATA_W-1:0] drd_data_o,
    input  logic              we_i,
    input  logic [AW-1:0]     widx_i,
    input  logic [DATA_W-1:0] wdata_i
);

    localparam int unsigned Depth = 2 ** AW;

    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] ird_data_q, ird_data_d;
    logic [DATA_W-1:0] drd_data_q, drd_data_d;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    always_comb begin
        ird_data_d = ird_data_q;
        if (ird_en_i) begin
            if (ird_zero_i) begin
                ird_data_d = '0;
            end else if (we_i && (widx_i == ird_idx_i)) begin
                ird_data_d = wdata_i;
            end else begin
                ird_data_d = mem_q[ird_idx_i];
            end
        end
    end

    // The data port is single-ported, so it never reads and writes on the same edge.
    always_comb begin
        drd_data_d = drd_data_q;
        if (drd_en_i) begin
            drd_data_d = drd_zero_i ? '0 : mem_q[drd_idx_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ird_data_q <= '0;
            drd_data_q <= '0;
        end else begin
            ird_data_q <= ird_data_d;
            drd_data_q <= drd_data_d;
        end
    end

    assign ird_data_o = ird_data_q;
    assign drd_data_o = drd_data_q;

endmodule

// File: rtl/toy_mem_responder.sv
// Unified memory responder for the RISC_TOY core: post-reset clear sweep,
// range checking and sticky ADDR_ERR. Define TOY_MEM_STAT_EN for access counters.
module toy_mem_responder
    import toy_mem_pkg::*;
#(
    parameter int unsigned AW       = 10,
    parameter int unsigned INIT_CLR = 1
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              IREQ,
    input  logic [ADDR_W-1:0] IADDR,
    output logic [DATA_W-1:0] INSTR,
    input  logic              DREQ,
    input  logic              DRW,
    input  logic [ADDR_W-1:0] DADDR,
    input  logic [DATA_W-1:0] DWDATA,
    output logic [DATA_W-1:0] DRDATA,
    output logic              BUSY,
`ifdef TOY_MEM_STAT_EN
    output logic [15:0]       STAT_IRD,
    output logic [15:0]       STAT_DWR,
`endif
    output logic              ADDR_ERR
);

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            addr_err_q, addr_err_d;

    logic            ready;
    logic            i_oor, d_oor;
    logic            ird_en, drd_en, d_wr_acc;
    logic            we;
    logic [AW-1:0]   widx;
    logic [DATA_W-1:0] wdata;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            if (INIT_CLR != 0) begin
                state_q <= CLEAR;
            end else begin
                state_q <= READY;
            end
            clr_idx_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == '1) begin
                    state_d = READY;
                end
            end
            READY: begin
            end
            default: begin
            end
        endcase
    end

    assign ready = (state_q == READY);
    assign BUSY  = (state_q == CLEAR);

    assign i_oor    = addr_oor(IADDR, AW);
    assign d_oor    = addr_oor(DADDR, AW);
    assign ird_en   = ready && IREQ;
    assign drd_en   = ready && DREQ && (DRW == DRW_RD);
    assign d_wr_acc = ready && DREQ && (DRW == DRW_WR) && !d_oor;

    // The sweep borrows the single write port; requests are not served meanwhile.
    always_comb begin
        we    = d_wr_acc;
        widx  = DADDR[AW-1:0];
        wdata = DWDATA;
        if (state_q == CLEAR) begin
            we    = 1'b1;
            widx  = clr_idx_q;
            wdata = '0;
        end
    end

    always_comb begin
        addr_err_d = addr_err_q;
        if (ready && ((IREQ && i_oor) || (DREQ && d_oor))) begin
            addr_err_d = 1'b1;
        end
    end

    assign ADDR_ERR = addr_err_q;

    toy_mem_array #(
        .AW(AW)
    ) u_array (
        .clk_i      (CLK),
        .rst_ni     (RSTN),
        .ird_en_i   (ird_en),
        .ird_zero_i (i_oor),
        .ird_idx_i  (IADDR[AW-1:0]),
        .ird_data_o (INSTR),
        .drd_en_i   (drd_en),
        .drd_zero_i (d_oor),
        .drd_idx_i  (DADDR[AW-1:0]),
        .drd_data_o (DRDATA),
        .we_i       (we),
        .widx_i     (widx),
        .wdata_i    (wdata)
    );

`ifdef TOY_MEM_STAT_EN
    logic [15:0] stat_ird_q, stat_ird_d;
    logic [15:0] stat_dwr_q, stat_dwr_d;

    always_comb begin
        stat_ird_d = stat_ird_q;
        stat_dwr_d = stat_dwr_q;
        if (ird_en && !i_oor && (stat_ird_q != 16'hFFFF)) begin
            stat_ird_d = stat_ird_q + 16'd1;
        end
        if (d_wr_acc && (stat_dwr_q != 16'hFFFF)) begin
            stat_dwr_d = stat_dwr_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            stat_ird_q <= '0;
            stat_dwr_q <= '0;
        end else begin
            stat_ird_q <= stat_ird_d;
            stat_dwr_q <= stat_dwr_d;
        end
    end

    assign STAT_IRD = stat_ird_q;
    assign STAT_DWR = stat_dwr_q;
`endif

endmodule

// File: tb/tb_toy_mem_responder.sv
// Directed bench: AW=4 instance with clear sweep, AW=10 instance without.
module tb_toy_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        ireq, dreq, drw;
    logic [29:0] iaddr, daddr;
    logic [31:0] dwdata, instr, drdata;
    logic        busy, err;

    logic        b_ireq, b_dreq, b_drw;
    logic [29:0] b_iaddr, b_daddr;
    logic [31:0] b_dwdata, b_instr, b_drdata;
    logic        b_busy, b_err;

`ifdef TOY_MEM_STAT_EN
    logic [15:0] stat_ird, stat_dwr;
`endif

    toy_mem_responder #(
        .AW       (4),
        .INIT_CLR (1)
    ) dut (
        .CLK      (clk),
        .RSTN     (rstn),
        .IREQ     (ireq),
        .IADDR    (iaddr),
        .INSTR    (instr),
        .DREQ     (dreq),
        .DRW      (drw),
        .DADDR    (daddr),
        .DWDATA   (dwdata),
        .DRDATA   (drdata),
        .BUSY     (busy),
`ifdef TOY_MEM_STAT_EN
        .STAT_IRD (stat_ird),
        .STAT_DWR (stat_dwr),
`endif
        .ADDR_ERR (err)
    );

    toy_mem_responder #(
        .AW       (10),
        .INIT_CLR (0)
    ) dut_b (
        .CLK      (clk),
        .RSTN     (rstn),
        .IREQ     (b_ireq),
        .IADDR    (b_iaddr),
        .INSTR    (b_instr),
        .DREQ     (b_dreq),
        .DRW      (b_drw),
        .DADDR    (b_daddr),
        .DWDATA   (b_dwdata),
        .DRDATA   (b_drdata),
        .BUSY     (b_busy),
`ifdef TOY_MEM_STAT_EN
        .STAT_IRD (),
        .STAT_DWR (),
`endif
        .ADDR_ERR (b_err)
    );

    typedef struct {
        logic        ireq;
        logic [29:0] iaddr;
        logic        dreq;
        logic        drw;
        logic [29:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] exp_instr;
        logic [31:0] exp_drdata;
        logic        exp_err;
    } vec_t;

    vec_t tv[13];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic i_r, input logic [29:0] i_a, input logic d_r,
                         input logic d_w, input logic [29:0] d_a, input logic [31:0] d_d);
        ireq   = i_r;
        iaddr  = i_a;
        dreq   = d_r;
        drw    = d_w;
        daddr  = d_a;
        dwdata = d_d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;

        tv[0]  = '{1'b0, 30'd0,  1'b1, 1'b1, 30'd5,         32'hDEADBEEF, 32'h0,        32'h0,        1'b0};
        tv[1]  = '{1'b0, 30'd0,  1'b1, 1'b0, 30'd5,         32'h0,        32'h0,        32'hDEADBEEF, 1'b0};
        tv[2]  = '{1'b1, 30'd3,  1'b1, 1'b1, 30'd3,         32'h12345678, 32'h12345678, 32'hDEADBEEF, 1'b0};
        tv[3]  = '{1'b1, 30'd5,  1'b1, 1'b0, 30'd3,         32'h0,        32'hDEADBEEF, 32'h12345678, 1'b0};
        tv[4]  = '{1'b0, 30'd0,  1'b0, 1'b0, 30'd0,         32'h0,        32'hDEADBEEF, 32'h12345678, 1'b0};
        tv[5]  = '{1'b1, 30'd3,  1'b1, 1'b1, 30'd5,         32'hA5A5A5A5, 32'h12345678, 32'h12345678, 1'b0};
        tv[6]  = '{1'b1, 30'd5,  1'b1, 1'b0, 30'd0,         32'h0,        32'hA5A5A5A5, 32'h0,        1'b0};
        tv[7]  = '{1'b1, 30'd15, 1'b1, 1'b1, 30'd15,        32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0,        1'b0};
        tv[8]  = '{1'b0, 30'd0,  1'b1, 1'b0, 30'd15,        32'h0,        32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0};
        tv[9]  = '{1'b1, 30'h10, 1'b1, 1'b0, 30'd5,         32'h0,        32'h0,        32'hA5A5A5A5, 1'b1};
        tv[10] = '{1'b0, 30'd0,  1'b1, 1'b1, 30'h13,        32'hFFFFFFFF, 32'h0,        32'hA5A5A5A5, 1'b1};
        tv[11] = '{1'b1, 30'd3,  1'b1, 1'b0, 30'd3,         32'h0,        32'h12345678, 32'h12345678, 1'b1};
        tv[12] = '{1'b0, 30'd0,  1'b1, 1'b0, 30'h20000003,  32'h0,        32'h12345678, 32'h0,        1'b1};

        rstn = 1'b0;
        drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'h0);
        b_ireq = 1'b0; b_iaddr = '0; b_dreq = 1'b0; b_drw = 1'b0; b_daddr = '0; b_dwdata = '0;
        repeat (2) tick();

        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_instr", instr, 32'h0);
        chk("rst_drdata", drdata, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);

        // Abort the first sweep at idx 7.
        @(negedge clk) rstn = 1'b1;
        repeat (7) @(posedge clk);
        #1 chk("busy_pre_abort", 32'(busy), 32'd1);
        @(negedge clk) rstn = 1'b0;
        #1 chk("busy_in_reset", 32'(busy), 32'd1);

        // Requests during the restarted sweep must all be ignored.
        @(negedge clk) rstn = 1'b1;
        drive(1'b1, 30'd9, 1'b1, 1'b0, 30'h400, 32'hBAD0BAD0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            cnt++;
            if (!busy) break;
            @(negedge clk);
            drive(1'b1, 30'd9, 1'b1, k[0], k[0] ? 30'd2 : 30'h400, 32'hBAD0BAD0);
        end
        chk("busy_len", 32'(cnt), 32'd16);
        chk("clear_instr", instr, 32'h0);
        chk("clear_drdata", drdata, 32'h0);
        chk("clear_err", 32'(err), 32'd0);
        chk("b_busy_ready", 32'(b_busy), 32'd0);

        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            drive(1'b1, 30'(a), 1'b1, 1'b0, 30'(a), 32'h0);
            tick();
            chk($sformatf("zero_d%0d", a), drdata, 32'h0);
            chk($sformatf("zero_i%0d", a), instr, 32'h0);
        end

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(tv[i].ireq, tv[i].iaddr, tv[i].dreq, tv[i].drw, tv[i].daddr, tv[i].dwdata);
            tick();
            chk($sformatf("v%0d_instr", i), instr, tv[i].exp_instr);
            chk($sformatf("v%0d_drdata", i), drdata, tv[i].exp_drdata);
            chk($sformatf("v%0d_err", i), 32'(err), 32'(tv[i].exp_err));
        end
        @(negedge clk);
        drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'h0);

        // AW=10 instance: out-of-range write must not alias onto index 0.
        b_dreq = 1'b1; b_drw = 1'b1; b_daddr = 30'd0; b_dwdata = 32'h11223344;
        tick();
        chk("b_err_clean", 32'(b_err), 32'd0);
        @(negedge clk);
        b_daddr = 30'h400; b_dwdata = 32'h55555555;
        tick();
        chk("b_err_set", 32'(b_err), 32'd1);
        @(negedge clk);
        b_drw = 1'b0; b_daddr = 30'd0; b_ireq = 1'b1; b_iaddr = 30'd0;
        tick();
        chk("b_rd0", b_drdata, 32'h11223344);
        chk("b_if0", b_instr, 32'h11223344);
        @(negedge clk);
        b_dreq = 1'b0; b_ireq = 1'b0;
        repeat (10) tick();
        chk("b_err_sticky", 32'(b_err), 32'd1);
        chk("b_rd0_hold", b_drdata, 32'h11223344);

`ifdef TOY_MEM_STAT_EN
        @(negedge clk) rstn = 1'b0;
        @(negedge clk) rstn = 1'b1;
        drive(1'b1, 30'd1, 1'b1, 1'b1, 30'd1, 32'h1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            cnt++;
            if (!busy) break;
        end
        chk("stat_busy_len", 32'(cnt), 32'd16);
        chk("stat_ird_clear", 32'(stat_ird), 32'd0);
        chk("stat_dwr_clear", 32'(stat_dwr), 32'd0);
        @(negedge clk) drive(1'b1, 30'd1, 1'b1, 1'b1, 30'd4, 32'h4);
        @(negedge clk) drive(1'b1, 30'd2, 1'b1, 1'b1, 30'd5, 32'h5);
        @(negedge clk) drive(1'b1, 30'd3, 1'b1, 1'b1, 30'h10, 32'h6);
        @(negedge clk) drive(1'b1, 30'h20, 1'b0, 1'b0, 30'd0, 32'h0);
        @(negedge clk) drive(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'h0);
        tick();
        chk("stat_ird", 32'(stat_ird), 32'd3);
        chk("stat_dwr", 32'(stat_dwr), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
